// File: rtl/pc_fetch_stage.sv
// -----------------------------------------------------------------------------
// pc_fetch_stage
//   Instruction-fetch stage. It holds the program counter and drives the
//   instruction-memory request and address. It also produces PC+1 for the
//   PC-source mux (mux6, input in_adder1). Fetched words are captured into
//   the IF/ID pipeline register.
//
//   The stage copes with three kinds of disturbance:
//     - memory wait states (imem_ready low)
//     - hazard stalls (stall_if)
//     - branch flushes (flush_if)
//   Their priority is flush > stall > wait.
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_next_pc    next PC from mux6 out_pc (sampled only on advance or flush)
//   stall_if      hazard stall: hold PC and IF/ID
//   flush_if      branch taken: squash IF/ID, load in_next_pc
//   imem_ready    instruction memory returns valid data this cycle
//   imem_rdata    instruction read data
//   imem_req      fetch request (high in FETCH and WAIT)
//   imem_addr     fetch address, always equal to pc
//   out_pc_plus1  pc + 1 modulo 2^ADDR_W, feeds mux6 in_adder1
//   if_id_pc      PC of the instruction held in IF/ID
//   if_id_instr   instruction held in IF/ID
//   if_id_valid   IF/ID holds a real instruction (0 = bubble)
// -----------------------------------------------------------------------------
module pc_fetch_stage #(
  parameter int unsigned         ADDR_W   = 5,
  parameter int unsigned         INSTR_W  = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  in_next_pc,
  input  logic               stall_if,
  input  logic               flush_if,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [ADDR_W-1:0]  out_pc_plus1,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic               if_id_valid
);

  // FETCH and WAIT behave identically. WAIT only records that the previous
  // request was not answered.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic              fetching;
  logic              flush_go;

  assign fetching     = (state == S_FETCH) || (state == S_WAIT);
  // A flush is ignored in IDLE: there is no request yet to redirect.
  assign flush_go     = flush_if && (state != S_IDLE);

  assign imem_req     = fetching;
  assign imem_addr    = pc;
  // Natural truncation gives the 11111 -> 00000 wrap with no carry out.
  assign out_pc_plus1 = pc + ADDR_W'(1);

  // NOTE: all state here uses non-blocking assignments. Every register then
  // updates from the same pre-edge values, which is what a pipeline needs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= RESET_PC;
      if_id_pc    <= '0;
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
    end else if (flush_go) begin
      // Redirect wins over everything. An outstanding WAIT is simply
      // abandoned, so the new address is presented next cycle.
      pc          <= in_next_pc;
      if_id_valid <= 1'b0;
      state       <= S_FETCH;
    end else begin
      unique case (state)
        S_IDLE: begin
          state <= S_FETCH;
        end
        S_FETCH, S_WAIT: begin
          if (stall_if) begin
            // IF/ID is frozen, valid included, so the consumer sees the
            // same instruction for the whole stall.
            state <= S_HOLD;
          end else if (imem_ready) begin
            if_id_instr <= imem_rdata;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
            pc          <= in_next_pc;
            state       <= S_FETCH;
          end else begin
            // Memory not ready: keep the address stable and feed a bubble.
            if_id_valid <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_HOLD: begin
          // Any data returned while holding is dropped. The same pc is
          // fetched again once the stall releases.
          if (!stall_if) begin
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
